// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: resyncs the 1 kHz strobe, steps one digit per strobe,
// blanks all anodes for BLANK_CYCLES after each switch, shadows value/dp_in once per frame.
// Ports: clk/rst (sync, active-high), scan_clk_in (async strobe), value/dp_in/lz_blank/enable in;
//        an/seg/dp registered pin drives, frame_done one-clk pulse on shadow reload.
module seg7_scan_driver #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_clk_in,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_blank,
    input  logic                  enable,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned CNT_W = $clog2(BLANK_CYCLES) + 1;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW  ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF   = SEG_ACTIVE_LOW;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      digit_idx;
    logic [CNT_W-1:0]      blank_cnt;
    logic [4*DIGITS-1:0]   shadow_val;
    logic [DIGITS-1:0]     shadow_dp;

    // Strobe synchroniser: s1/s2 resync, s3 is edge-detect history.
    logic                  s1, s2, s3;
    // fill_cnt/armed keep a strobe that is already high when reset releases from
    // looking like a fresh rising edge: a tick is only accepted after s2 has been
    // seen low with real (post-reset) data in it.
    logic [1:0]            fill_cnt;
    logic                  armed;
    logic                  tick;

    assign tick = s2 & ~s3 & armed;

    // Segment decode, active-high {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic [DIGITS-1:0] onehot;
    logic [DIGITS-1:0] lz_sup;
    logic              zero_run;
    logic              drive_on;
    logic [6:0]        seg_hi;
    logic [DIGITS-1:0] an_nxt;
    logic [6:0]        seg_nxt;
    logic              dp_nxt;

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        onehot  = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nib   = shadow_val[4*i +: 4];
                cur_dp    = shadow_dp[i];
                onehot[i] = 1'b1;
            end
        end

        // A digit is a leading zero when it and every digit above it are zero;
        // a lit decimal point on the digit itself keeps it visible.
        zero_run = 1'b1;
        lz_sup   = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_run  = zero_run & (shadow_val[4*i +: 4] == 4'h0);
            lz_sup[i] = zero_run & ~shadow_dp[i];
        end

        drive_on = (state == ST_DRIVE) && !(lz_blank && |(lz_sup & onehot));
        seg_hi   = hex_decode(cur_nib);

        an_nxt  = (drive_on && enable) ? (AN_ACTIVE_LOW ? ~onehot : onehot) : AN_OFF;
        seg_nxt = drive_on ? (SEG_ACTIVE_LOW ? ~seg_hi : seg_hi) : SEG_OFF;
        dp_nxt  = drive_on ? (SEG_ACTIVE_LOW ? ~cur_dp : cur_dp) : DP_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            fill_cnt   <= 2'd0;
            armed      <= 1'b0;
            state      <= ST_BLANK;
            digit_idx  <= '0;
            blank_cnt  <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            frame_done <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
        end else begin
            s1 <= scan_clk_in;
            s2 <= s1;
            s3 <= s2;
            if (fill_cnt != 2'd2) begin
                fill_cnt <= fill_cnt + 2'd1;
            end
            if (fill_cnt == 2'd2 && !s2) begin
                armed <= 1'b1;
            end

            frame_done <= tick && (digit_idx == LAST_IDX);

            if (tick) begin
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
                state     <= ST_BLANK;
                blank_cnt <= '0;
                if (digit_idx == LAST_IDX) begin
                    shadow_val <= value;
                    shadow_dp  <= dp_in;
                end
            end else begin
                case (state)
                    ST_BLANK: begin
                        blank_cnt <= blank_cnt + 1'b1;
                        if (blank_cnt == CNT_LAST) begin
                            state <= ST_DRIVE;
                        end
                    end
                    default: ;  // ST_DRIVE holds until the next tick
                endcase
            end

            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule
